// File: rtl/line_stream_gen.sv
// Frame-structured pixel source: LINES lines of LINE_LEN pixels separated by HBLANK idle cycles,
// with a start/busy/done handshake and four selectable data patterns.
module line_stream_gen #(
    parameter int unsigned LINE_LEN = 8,
    parameter int unsigned LINES    = 4,
    parameter int unsigned HBLANK   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       en,
    output logic [7:0] outdata,
    output logic       line_last,
    output logic       frame_last
);
    localparam int unsigned CW = 10;
    localparam int unsigned BW = 8;
    localparam int unsigned DW = 8;
    localparam logic [CW-1:0] COL_LAST   = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(LINES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(HBLANK - 1);
    localparam logic [DW-1:0] LFSR_SEED  = DW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_col, w_col;
    logic [CW-1:0]   r_row, w_row;
    logic [BW-1:0]   r_blank, w_blank;
    logic [DW-1:0]   r_lfsr, w_lfsr;
    logic [1:0]      r_mode, w_mode;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_en, w_en;
    logic [DW-1:0]   r_outdata, w_outdata;
    logic            r_line_last, w_line_last;
    logic            r_frame_last, w_frame_last;
    logic [DW-1:0]   w_lfsr_step;

    // Pixel value for a given position; the LFSR value is the one belonging to that pixel.
    function automatic logic [DW-1:0] pattern(input logic [1:0] md, input logic [CW-1:0] col,
                                              input logic [CW-1:0] row, input logic [DW-1:0] lfsr);
        case (md)
            2'd0:    pattern = DW'(col) + DW'(row);
            2'd1:    pattern = DW'(8'h55);
            2'd2:    pattern = DW'(col);
            default: pattern = lfsr;
        endcase
    endfunction

    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    // State and counters describe the cycle currently on the outputs; w_en marks a new pixel.
    always_comb begin
        w_state      = r_state;
        w_col        = r_col;
        w_row        = r_row;
        w_blank      = r_blank;
        w_lfsr       = r_lfsr;
        w_mode       = r_mode;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_en         = 1'b0;
        w_outdata    = '0;
        w_line_last  = 1'b0;
        w_frame_last = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_ACTIVE;
                    w_mode  = mode;
                    w_col   = '0;
                    w_row   = '0;
                    w_lfsr  = LFSR_SEED;
                    w_en    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (r_col == COL_LAST) begin
                    if (r_row == ROW_LAST) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else if (HBLANK > 0) begin
                        w_state = S_HBLANK;
                        w_blank = '0;
                        w_busy  = 1'b1;
                    end else begin
                        w_col  = '0;
                        w_row  = r_row + CW'(1);
                        w_lfsr = w_lfsr_step;
                        w_en   = 1'b1;
                    end
                end else begin
                    w_col  = r_col + CW'(1);
                    w_lfsr = w_lfsr_step;
                    w_en   = 1'b1;
                end
            end
            S_HBLANK: begin
                w_busy = 1'b1;
                if (r_blank == BLANK_LAST) begin
                    w_state = S_ACTIVE;
                    w_col   = '0;
                    w_row   = r_row + CW'(1);
                    w_lfsr  = w_lfsr_step;
                    w_en    = 1'b1;
                end else begin
                    w_blank = r_blank + BW'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_en) begin
            w_busy       = 1'b1;
            w_outdata    = pattern(w_mode, w_col, w_row, w_lfsr);
            w_line_last  = (w_col == COL_LAST);
            w_frame_last = (w_col == COL_LAST) && (w_row == ROW_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_blank      <= '0;
            r_lfsr       <= LFSR_SEED;
            r_mode       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_en         <= 1'b0;
            r_outdata    <= '0;
            r_line_last  <= 1'b0;
            r_frame_last <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_col        <= w_col;
            r_row        <= w_row;
            r_blank      <= w_blank;
            r_lfsr       <= w_lfsr;
            r_mode       <= w_mode;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_en         <= w_en;
            r_outdata    <= w_outdata;
            r_line_last  <= w_line_last;
            r_frame_last <= w_frame_last;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign en         = r_en;
    assign outdata    = r_outdata;
    assign line_last  = r_line_last;
    assign frame_last = r_frame_last;

endmodule

// File: tb/tb_line_stream_gen.sv
// Bench for line_stream_gen: frame-position reference model checked every cycle on two
// parameterisations, plus hand-computed pixel values at chosen cycles.
module tb_line_stream_gen;
    localparam int LL_A = 8;
    localparam int NL_A = 4;
    localparam int HB_A = 2;
    localparam int LL_B = 1;
    localparam int NL_B = 1;
    localparam int HB_B = 0;
    localparam int LAST_A = NL_A * LL_A + (NL_A - 1) * HB_A;
    localparam int LAST_B = NL_B * LL_B + (NL_B - 1) * HB_B;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       en;
        logic [7:0] data;
        logic       ll;
        logic       fl;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [1:0] mode_a, mode_b;
    logic       busy_a, done_a, en_a, line_last_a, frame_last_a;
    logic       busy_b, done_b, en_b, line_last_b, frame_last_b;
    logic [7:0] outdata_a, outdata_b;

    int n_chk  = 0;
    int n_fail = 0;
    int rel    = 0;
    bit chk_on = 1'b0;

    int         ma_t = 0, mb_t = 0;
    logic [1:0] ma_mode = '0, mb_mode = '0;

    line_stream_gen #(.LINE_LEN(LL_A), .LINES(NL_A), .HBLANK(HB_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .busy(busy_a), .done(done_a), .en(en_a), .outdata(outdata_a),
        .line_last(line_last_a), .frame_last(frame_last_a)
    );

    line_stream_gen #(.LINE_LEN(LL_B), .LINES(NL_B), .HBLANK(HB_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .busy(busy_b), .done(done_b), .en(en_b), .outdata(outdata_b),
        .line_last(line_last_b), .frame_last(frame_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Expected outputs at cycle t of a frame (t=1 first pixel, 0 = idle), from frame geometry alone.
    function automatic obs_t model_out(input int t, input logic [1:0] md,
                                       input int ll, input int nl, input int hb);
        obs_t o;
        int last, p, col, row, idx;
        logic [7:0] s;
        o = '0;
        last = nl * ll + (nl - 1) * hb;
        if (t >= 1 && t <= last) begin
            o.busy = 1'b1;
            p   = (t - 1) % (ll + hb);
            row = (t - 1) / (ll + hb);
            if (p < ll) begin
                col  = p;
                o.en = 1'b1;
                idx  = row * ll + col;
                s    = 8'h01;
                for (int i = 0; i < idx; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
                case (md)
                    2'd0:    o.data = 8'((col + row) % 256);
                    2'd1:    o.data = 8'h55;
                    2'd2:    o.data = 8'(col);
                    default: o.data = s;
                endcase
                o.ll = (col == ll - 1);
                o.fl = (col == ll - 1) && (row == nl - 1);
            end
        end else if (t == last + 1) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    // Frame-position tracker: accept in idle, count cycles, return to idle after done.
    always @(posedge clk) begin
        if (!rst_n) begin
            ma_t <= 0;
            mb_t <= 0;
        end else begin
            if (ma_t == 0) begin
                if (start_a) begin ma_t <= 1; ma_mode <= mode_a; end
            end else if (ma_t == LAST_A + 1) ma_t <= 0;
            else ma_t <= ma_t + 1;
            if (mb_t == 0) begin
                if (start_b) begin mb_t <= 1; mb_mode <= mode_b; end
            end else if (mb_t == LAST_B + 1) mb_t <= 0;
            else mb_t <= mb_t + 1;
        end
    end

    always @(negedge clk) begin
        obs_t ea, eb;
        if (chk_on) begin
            ea = model_out(ma_t, ma_mode, LL_A, NL_A, HB_A);
            eb = model_out(mb_t, mb_mode, LL_B, NL_B, HB_B);
            chk("A.busy", 32'(busy_a), 32'(ea.busy));
            chk("A.done", 32'(done_a), 32'(ea.done));
            chk("A.en", 32'(en_a), 32'(ea.en));
            chk("A.outdata", 32'(outdata_a), 32'(ea.data));
            chk("A.line_last", 32'(line_last_a), 32'(ea.ll));
            chk("A.frame_last", 32'(frame_last_a), 32'(ea.fl));
            chk("B.busy", 32'(busy_b), 32'(eb.busy));
            chk("B.done", 32'(done_b), 32'(eb.done));
            chk("B.en", 32'(en_b), 32'(eb.en));
            chk("B.outdata", 32'(outdata_b), 32'(eb.data));
            chk("B.line_last", 32'(line_last_b), 32'(eb.ll));
            chk("B.frame_last", 32'(frame_last_b), 32'(eb.fl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic tick_to(input int n);
        while (rel < n) tick();
    endtask

    task automatic accept(input logic [1:0] md, input bit hold);
        mode_a  = md;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        rel = 1;
        if (!hold) start_a = 1'b0;
    endtask

    initial begin
        logic [7:0] lfsr_exp [6];
        lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        rst_n = 1'b0; start_a = 1'b0; mode_a = '0; start_b = 1'b0; mode_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("rst.en", 32'(en_a), 32'd0);
        chk("rst.busy", 32'(busy_a), 32'd0);
        chk("rst.outdata", 32'(outdata_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Mode 0 ramp, with start pulses in an active, a blank and the done cycle.
        accept(2'd0, 1'b0);
        chk("m0.c1.en", 32'(en_a), 32'd1);
        chk("m0.c1.data", 32'(outdata_a), 32'd0);
        tick_to(5); start_a = 1'b1; tick_to(6); start_a = 1'b0;
        tick_to(8);
        chk("m0.c8.data", 32'(outdata_a), 32'd7);
        chk("m0.c8.line_last", 32'(line_last_a), 32'd1);
        tick_to(9);
        chk("m0.c9.en", 32'(en_a), 32'd0);
        chk("m0.c9.busy", 32'(busy_a), 32'd1);
        start_a = 1'b1; tick_to(10); start_a = 1'b0;
        tick_to(11);
        chk("m0.c11.data", 32'(outdata_a), 32'd1);
        tick_to(38);
        chk("m0.c38.data", 32'(outdata_a), 32'd10);
        chk("m0.c38.frame_last", 32'(frame_last_a), 32'd1);
        tick_to(39);
        chk("m0.c39.done", 32'(done_a), 32'd1);
        chk("m0.c39.busy", 32'(busy_a), 32'd0);
        start_a = 1'b1; tick_to(40); start_a = 1'b0;
        tick_to(42);
        chk("m0.c42.en", 32'(en_a), 32'd0);
        tick_to(45);

        // Mode 3 LFSR; a mode change mid-frame must not alter the pattern.
        accept(2'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick_to(i + 1);
            chk("m3.lfsr", 32'(outdata_a), 32'(lfsr_exp[i]));
            if (i == 2) mode_a = 2'd0;
        end
        tick_to(9);
        chk("m3.blank.data", 32'(outdata_a), 32'd0);
        tick_to(11);
        chk("m3.row1.data", 32'(outdata_a), 32'h1C);
        tick_to(45);

        // Start held high: back-to-back frames.
        accept(2'd0, 1'b1);
        tick_to(40);
        chk("hold.c40.en", 32'(en_a), 32'd0);
        tick_to(41);
        chk("hold.c41.en", 32'(en_a), 32'd1);
        chk("hold.c41.data", 32'(outdata_a), 32'd0);
        start_a = 1'b0;
        tick_to(85);

        // Reset mid-frame at row 1, col 3.
        accept(2'd0, 1'b0);
        tick_to(14);
        chk("rmid.c14.data", 32'(outdata_a), 32'd4);
        rst_n = 1'b0;
        tick_to(15);
        chk("rmid.en", 32'(en_a), 32'd0);
        chk("rmid.busy", 32'(busy_a), 32'd0);
        chk("rmid.outdata", 32'(outdata_a), 32'd0);
        rst_n = 1'b1;
        tick_to(60);
        accept(2'd0, 1'b0);
        chk("rmid.restart.en", 32'(en_a), 32'd1);
        chk("rmid.restart.data", 32'(outdata_a), 32'd0);
        tick_to(45);

        // Modes 1 and 2.
        accept(2'd1, 1'b0);
        tick_to(19);
        chk("m1.blank.data", 32'(outdata_a), 32'd0);
        tick_to(21);
        chk("m1.c21.data", 32'(outdata_a), 32'h55);
        tick_to(45);
        accept(2'd2, 1'b0);
        tick_to(18);
        chk("m2.c18.data", 32'(outdata_a), 32'd7);
        chk("m2.c18.line_last", 32'(line_last_a), 32'd1);
        tick_to(45);

        // Single-pixel frame instance.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b.c1.en", 32'(en_b), 32'd1);
        chk("b.c1.line_last", 32'(line_last_b), 32'd1);
        chk("b.c1.frame_last", 32'(frame_last_b), 32'd1);
        tick();
        chk("b.c2.done", 32'(done_b), 32'd1);
        chk("b.c2.busy", 32'(busy_b), 32'd0);
        repeat (4) tick();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/line_stream_gen.md
# line_stream_gen

Frame-structured pixel stream source that drives the `en`/8-bit data input of the line-buffer adder. It emits `LINES` lines of `LINE_LEN` pixels, with `HBLANK` idle cycles between lines and a selectable data pattern. A start/busy/done handshake lets a bench or top-level controller request one frame at a time.

## Interface
- `LINE_LEN`, 8: pixels per line, ≥1, ≤1024.
- `LINES`, 4: lines per frame, ≥1, ≤1024.
- `HBLANK`, 2: idle cycles between consecutive lines, ≥0, ≤255. No blank follows the last line.

- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: frame request. Sampled only in IDLE.
- `mode` in 2: pattern select. Latched when `start` is accepted.
- `busy` out 1: high from the first pixel cycle through the last pixel cycle, including blanks.
- `done` out 1: one-cycle pulse in the cycle after the last pixel.
- `en` out 1: pixel valid. Drives the adder's `en`.
- `outdata` out 8: pixel value. Drives the adder's `indata`. It is 0 whenever `en`=0.
- `line_last` out 1: high with the last pixel of every line.
- `frame_last` out 1: high with the last pixel of the frame.

## Operation
- All outputs are registered.
- Reset value of every output is 0. The FSM resets to IDLE. Column, row and blank counters reset to 0. The LFSR resets to 0x01.
- FSM states are IDLE, ACTIVE, HBLANK and DONE.
- **IDLE**: `start`=1 moves the FSM to ACTIVE. On that transition:
  - latch `mode`;
  - clear col/row;
  - seed the LFSR to 0x01;
  - register pixel (col 0, row 0) with `en`=1.
- **ACTIVE**: emits one pixel per cycle and increments col.
  - At col=LINE_LEN-1, `line_last`=1.
  - If row=LINES-1 on that pixel, `frame_last`=1 as well, and the next state is DONE.
  - Otherwise, the next state is HBLANK if HBLANK>0, or ACTIVE at col 0, row+1 if HBLANK=0.
- **HBLANK**: `en`=0 and `outdata`=0 for exactly HBLANK cycles. The FSM then returns to ACTIVE at col 0, row+1.
- **DONE**: `done`=1 and `busy`=0 for one cycle, then IDLE. `start` is ignored in DONE, ACTIVE and HBLANK.
- Pattern (`outdata` while `en`=1), fixed by the latched mode:
  - 0 ramp: (col+row) mod 256.
  - 1 constant: 0x55.
  - 2 column: col[7:0].
  - 3 LFSR: current LFSR state.
- LFSR behaviour: Fibonacci, next = {s[6:0], s[7]^s[5]^s[4]^s[3]}. It advances only on cycles with `en`=1 and is not reset between lines.
- Counter width: col and row are 10 bits, ramp addition is truncated to 8 bits, and the blank counter is 8 bits.

## Timing
- Latency: `start` sampled at edge k gives first pixel valid in the cycle after edge k (cycle 1).
- Last pixel falls in cycle LINES·LINE_LEN + (LINES-1)·HBLANK. `done` follows in the next cycle.
- `busy` is high exactly on cycles 1 through the last pixel cycle.
- With `start` held high, the next frame's first pixel comes 2 cycles after `done`: DONE → IDLE (accept) → pixel.
- `line_last` and `frame_last` are asserted only together with `en`=1.
- Reset mid-frame: with `rst_n`=0 at any edge, every output is 0 in the following cycle and the FSM is in IDLE. No `done` pulse is produced. The next `start` begins again at col 0, row 0 with a fresh LFSR seed.
- A `mode` change after acceptance has no effect until the next frame.

## Test plan
- Reset, then `start` with mode 0 and defaults:
  - rows emit 0..7, 1..8, 2..9 and 3..10, with 2 `en`=0 cycles between rows;
  - `line_last` in cycles 8, 18, 28 and 38;
  - `frame_last` in cycle 38, `done` in cycle 39, and `busy` high in cycles 1–38 only.
- Mode 3: the first six pixels are 0x01, 0x02, 0x04, 0x08, 0x11, 0x23. The LFSR holds during blanks, and row 1 continues the sequence.
- `start` pulsed in cycles 5, 9 (blank) and 39 (DONE) is ignored, giving exactly one frame. With `start` held high, the second frame's first pixel comes in cycle 41.
- `rst_n` low in the cycle of row 1, col 3 gives all outputs 0 next cycle and no `done`. A new `start` restarts at row 0 with value 0 (mode 0).
- `LINE_LEN`=1, `LINES`=1, `HBLANK`=0: a single pixel in cycle 1 with `line_last`=`frame_last`=1, `done` in cycle 2.
- Mode 1 gives 0x55 on all 32 pixels. Mode 2 gives 0..7 on every row. `outdata`=0 on all blank cycles in both.
